frame_bank_ctrl: RTL and testbench

- Double-buffer (ping-pong) scheduler for the camera frame buffer, which holds two banks of c_img_pxls words each.
- Sits between ov7670_capture and frame_buffer on the write port, and between vga_display and frame_buffer on the read port.
- Capture always writes one bank while the display reads the other; banks swap only at display frame boundaries, so no tearing.
- Whole captured frames are dropped when the display has not yet consumed the previous one.

---
 rtl/frame_bank_ctrl_pkg.sv | 23 ++
 rtl/frame_bank_ctrl.sv | 149 ++++++++++++++
 tb/tb_frame_bank_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_ctrl_pkg.sv
// frame_bank_ctrl_pkg
// Shared constants for the camera frame-buffer path and the state encoding
// of the ping-pong bank scheduler.
//   c_img_cols, c_img_rows : captured image geometry (80x60)
//   c_img_pxls             : words per bank
//   c_nb_img_pxls          : bits of per-bank pixel address
//   c_nb_buf               : bits of full buffer address (two banks)
//   fsm_state_t            : scheduler states
package frame_bank_ctrl_pkg;

    localparam int c_img_cols    = 80;
    localparam int c_img_rows    = 60;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = $clog2(c_img_pxls);
    localparam int c_nb_buf      = c_nb_img_pxls + 1;

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_HOLD     = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/frame_bank_ctrl.sv
// frame_bank_ctrl
// Ping-pong scheduler for the two-bank camera frame buffer. Capture writes
// wr_bank while the display reads rd_bank; banks swap only at a display
// frame boundary, and captured frames arriving while a completed frame is
// still waiting are dropped whole.
//
// state       | meaning
// ------------+--------------------------------------------------------
// WAIT_SOF    | idle, waiting for a capture start-of-frame; no writes
// CAPTURE     | capture pixels are written into wr_bank
// HOLD        | wr_bank holds a completed frame, waiting for a display swap
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cap_frame_start   : capture start-of-frame pulse
//   cap_frame_done    : capture last-pixel pulse
//   cap_we/addr/data  : capture pixel write
//   disp_frame_done   : end of visible display frame pulse
//   disp_addr         : display read address
//   freeze            : inhibit swaps
//   mem_we/waddr/wdata: registered write port to frame_buffer
//   mem_raddr         : combinational read address to frame_buffer
//   wr_bank, rd_bank  : current bank owners (always complementary)
//   frame_ready       : completed frame waiting for a swap
//   drop_cnt          : dropped frames, saturating
//   done_cnt          : completed frames, wrapping
module frame_bank_ctrl
    import frame_bank_ctrl_pkg::*;
#(
    parameter int c_nb_addr = c_nb_img_pxls,
    parameter int c_nb_data = 12,
    parameter int c_nb_cnt  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cap_frame_start,
    input  logic                 cap_frame_done,
    input  logic                 cap_we,
    input  logic [c_nb_addr-1:0] cap_addr,
    input  logic [c_nb_data-1:0] cap_data,
    input  logic                 disp_frame_done,
    input  logic [c_nb_addr-1:0] disp_addr,
    input  logic                 freeze,
    output logic                 mem_we,
    output logic [c_nb_addr:0]   mem_waddr,
    output logic [c_nb_data-1:0] mem_wdata,
    output logic [c_nb_addr:0]   mem_raddr,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic                 frame_ready,
    output logic [c_nb_cnt-1:0]  drop_cnt,
    output logic [c_nb_cnt-1:0]  done_cnt
);

    fsm_state_t state;
    fsm_state_t state_nxt;
    logic       swap;
    logic       done_inc;
    logic       drop_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT_SOF;
        end else begin
            state <= state_nxt;
        end
    end

    // In CAPTURE a new start-of-frame outranks done: a truncated frame just
    // restarts in place. In HOLD a start that coincides with an allowed swap
    // is the first frame of the fresh bank, so it is not counted as dropped.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        done_inc  = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            ST_WAIT_SOF: begin
                if (cap_frame_start) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (cap_frame_start) begin
                    state_nxt = ST_CAPTURE;
                end else if (cap_frame_done) begin
                    done_inc = 1'b1;
                    if (disp_frame_done && !freeze) begin
                        swap      = 1'b1;
                        state_nxt = ST_WAIT_SOF;
                    end else begin
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (disp_frame_done && !freeze) begin
                    swap      = 1'b1;
                    state_nxt = cap_frame_start ? ST_CAPTURE : ST_WAIT_SOF;
                end else if (cap_frame_start) begin
                    drop_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
        end else if (swap) begin
            wr_bank <= ~wr_bank;
        end
    end

    // Derived rather than stored so the two banks can never alias.
    assign rd_bank     = ~wr_bank;
    assign frame_ready = (state == ST_HOLD);
    assign mem_raddr   = {rd_bank, disp_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we    <= cap_we && (state == ST_CAPTURE);
            mem_waddr <= {wr_bank, cap_addr};
            mem_wdata <= cap_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (done_inc) begin
                done_cnt <= done_cnt + 1'b1;
            end
            if (drop_inc && (drop_cnt != {c_nb_cnt{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_bank_ctrl.sv
module tb_frame_bank_ctrl;

    localparam int NA = 13;
    localparam int ND = 12;
    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cap_frame_start, cap_frame_done, cap_we;
    logic [NA-1:0] cap_addr;
    logic [ND-1:0] cap_data;
    logic          disp_frame_done;
    logic [NA-1:0] disp_addr;
    logic          freeze;
    logic          mem_we;
    logic [NA:0]   mem_waddr;
    logic [ND-1:0] mem_wdata;
    logic [NA:0]   mem_raddr;
    logic          wr_bank, rd_bank, frame_ready;
    logic [NC-1:0] drop_cnt, done_cnt;

    frame_bank_ctrl #(.c_nb_addr(NA), .c_nb_data(ND), .c_nb_cnt(NC)) dut (
        .clk(clk), .rst(rst),
        .cap_frame_start(cap_frame_start), .cap_frame_done(cap_frame_done),
        .cap_we(cap_we), .cap_addr(cap_addr), .cap_data(cap_data),
        .disp_frame_done(disp_frame_done), .disp_addr(disp_addr),
        .freeze(freeze),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .wr_bank(wr_bank), .rd_bank(rd_bank),
        .frame_ready(frame_ready), .drop_cnt(drop_cnt), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic          wb;
        logic          rb;
        logic          fr;
        logic [NC-1:0] drop;
        logic [NC-1:0] done;
        logic [NA:0]   raddr;
    } status_t;

    typedef struct packed {
        logic [NA:0]   addr;
        logic [ND-1:0] data;
    } wr_t;

    status_t sq[$];
    wr_t     wq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: which phase of the frame handshake we are in, the
    // bank owned by capture, and the two frame tallies as plain integers.
    bit m_waiting, m_capturing, m_holding;
    bit m_wbank;
    int m_drop, m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit s, input bit cd, input bit dd,
                              input bit fz, input bit we, input logic [NA-1:0] a,
                              input logic [ND-1:0] d, input logic [NA-1:0] da);
        status_t st;
        bit      wrote;
        wrote = 1'b0;
        if (r) begin
            m_waiting = 1; m_capturing = 0; m_holding = 0;
            m_wbank = 0; m_drop = 0; m_done = 0;
        end else begin
            if (m_capturing && we) begin
                wrote = 1'b1;
                wq.push_back({m_wbank, a, d});
            end
            if (m_waiting) begin
                if (s) begin m_waiting = 0; m_capturing = 1; end
            end else if (m_capturing) begin
                if (!s && cd) begin
                    m_done = (m_done + 1) % 256;
                    m_capturing = 0;
                    if (dd && !fz) begin
                        m_wbank = !m_wbank;
                        m_waiting = 1;
                    end else begin
                        m_holding = 1;
                    end
                end
            end else if (m_holding) begin
                if (dd && !fz) begin
                    m_wbank = !m_wbank;
                    m_holding = 0;
                    if (s) m_capturing = 1; else m_waiting = 1;
                end else if (s) begin
                    m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                end
            end
        end
        st.we    = wrote;
        st.wb    = m_wbank;
        st.rb    = !m_wbank;
        st.fr    = m_holding;
        st.drop  = NC'(m_drop);
        st.done  = NC'(m_done);
        st.raddr = {!m_wbank, da};
        sq.push_back(st);
    endtask

    task automatic cycle(input bit r, input bit s, input bit cd, input bit dd,
                         input bit fz, input bit we, input logic [NA-1:0] a,
                         input logic [ND-1:0] d, input logic [NA-1:0] da);
        @(negedge clk);
        rst = r; cap_frame_start = s; cap_frame_done = cd; disp_frame_done = dd;
        freeze = fz; cap_we = we; cap_addr = a; cap_data = d; disp_addr = da;
        model_step(r, s, cd, dd, fz, we, a, d, da);
    endtask

    task automatic idle(input bit fz, input bit we);
        cycle(0, 0, 0, 0, fz, we, 13'd5, 12'hABC, 13'd7);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one status entry per clock; a write entry only when the DUT
    // presents a write.
    initial begin
        status_t exp_s, act_s;
        wr_t     exp_w;
        forever begin
            @(posedge clk);
            #1;
            if (sq.size() > 0) begin
                exp_s = sq.pop_front();
                act_s = {mem_we, wr_bank, rd_bank, frame_ready, drop_cnt, done_cnt, mem_raddr};
                checks++;
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL status actual we=%b wb=%b rb=%b fr=%b drop=%0d done=%0d raddr=%0h required we=%b wb=%b rb=%b fr=%b drop=%0d done=%0d raddr=%0h",
                             act_s.we, act_s.wb, act_s.rb, act_s.fr, act_s.drop, act_s.done, act_s.raddr,
                             exp_s.we, exp_s.wb, exp_s.rb, exp_s.fr, exp_s.drop, exp_s.done, exp_s.raddr);
                end
            end
            if (mem_we === 1'b1) begin
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0h data=%0h required none", mem_waddr, mem_wdata);
                end else begin
                    exp_w = wq.pop_front();
                    if ({mem_waddr, mem_wdata} !== exp_w) begin
                        errors++;
                        $display("FAIL write actual addr=%0h data=%0h required addr=%0h data=%0h",
                                 mem_waddr, mem_wdata, exp_w.addr, exp_w.data);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1; cap_frame_start = 0; cap_frame_done = 0; disp_frame_done = 0;
        freeze = 0; cap_we = 0; cap_addr = '0; cap_data = '0; disp_addr = '0;

        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("reset_wr_bank", 32'(wr_bank), 0);
        chk("reset_rd_bank", 32'(rd_bank), 1);
        chk("reset_mem_we", 32'(mem_we), 0);
        chk("reset_mem_waddr", 32'(mem_waddr), 0);
        chk("reset_mem_wdata", 32'(mem_wdata), 0);
        chk("reset_counts", {16'd0, drop_cnt, done_cnt}, 0);

        // Writes without a start-of-frame are suppressed.
        idle(0, 1);
        settle();
        chk("no_sof_write", 32'(mem_we), 0);

        // Start, then one pixel: registered write one cycle later.
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 13'd5, 12'hABC, 0);
        settle();
        chk("first_write_we", 32'(mem_we), 1);
        chk("first_write_addr", 32'(mem_waddr), 32'h0005);
        chk("first_write_data", 32'(mem_wdata), 32'hABC);

        // Done, display done 10 cycles later, then swap.
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) idle(0, 0);
        settle();
        chk("hold_frame_ready", 32'(frame_ready), 1);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 13'd7);
        settle();
        chk("swap_wr_bank", 32'(wr_bank), 1);
        chk("swap_rd_bank", 32'(rd_bank), 0);
        chk("swap_raddr", 32'(mem_raddr), 32'h0007);
        chk("swap_done_cnt", 32'(done_cnt), 1);
        chk("swap_frame_ready", 32'(frame_ready), 0);

        // Three dropped frames in HOLD, with capture strobes active.
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 1, 13'd1, 12'h111, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 0, 1, 13'd2, 12'h222, 0);
            idle(0, 1);
        end
        settle();
        chk("drop_three", 32'(drop_cnt), 3);
        chk("drop_no_write", 32'(mem_we), 0);

        // Freeze blocks the swap; releasing it allows the next one.
        cycle(0, 0, 0, 1, 1, 0, 0, 0, 0);
        settle();
        chk("freeze_no_swap", 32'(wr_bank), 1);
        cycle(0, 0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        chk("unfreeze_swap", 32'(wr_bank), 0);

        // Capture done and display done in the same cycle.
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        chk("coinc_swap", 32'(wr_bank), 1);
        chk("coinc_frame_ready", 32'(frame_ready), 0);
        chk("coinc_drop", 32'(drop_cnt), 3);
        chk("coinc_done", 32'(done_cnt), 3);

        // Saturation under freeze, then swap with simultaneous start.
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            cycle(0, 1, 0, 0, 1, 0, 0, 0, 0);
            idle(1, 0);
        end
        settle();
        chk("drop_saturated", 32'(drop_cnt), 255);
        cycle(0, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 13'd9, 12'h123, 0);
        settle();
        chk("swap_start_we", 32'(mem_we), 1);
        chk("swap_start_addr", 32'(mem_waddr), 32'h0009);
        chk("swap_start_drop", 32'(drop_cnt), 255);

        // Reset mid-capture.
        cycle(0, 0, 0, 0, 0, 1, 13'd10, 12'h321, 0);
        cycle(1, 0, 0, 0, 0, 1, 13'd11, 12'h456, 0);
        settle();
        chk("midrst_we", 32'(mem_we), 0);
        chk("midrst_waddr", 32'(mem_waddr), 0);
        chk("midrst_wbank", 32'(wr_bank), 0);
        chk("midrst_counts", {16'd0, drop_cnt, done_cnt}, 0);
        idle(0, 1);
        settle();
        chk("postrst_no_write", 32'(mem_we), 0);

        // Randomised traffic against the reference model.
        begin
            bit fz;
            fz = 0;
            for (int i = 0; i < 4000; i++) begin
                bit r, s, cd, dd, we;
                r  = ($urandom_range(0, 799) == 0);
                s  = ($urandom_range(0, 19) == 0);
                cd = !s && ($urandom_range(0, 19) == 0);
                dd = ($urandom_range(0, 14) == 0);
                we = ($urandom_range(0, 1) == 1);
                if ($urandom_range(0, 59) == 0) fz = !fz;
                cycle(r, s, cd, dd, fz, we, NA'($urandom), ND'($urandom), NA'($urandom));
            end
        end

        idle(0, 0);
        settle();
        @(posedge clk);
        #3;
        chk("status_queue_drained", 32'(sq.size()), 0);
        chk("write_queue_drained", 32'(wq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
